pc_predict_unit: RTL

- Fetch-stage PC selection and prediction block for the pipelined Y86-64 core; successor to the single-cycle PC update.
- Holds the predicted-PC register and selects the fetch PC from three sources: prediction, M-stage branch-mispredict recovery, and W-stage return resolution.
- Adds a parametrised branch-prediction mode, a halt state machine, and an optional return-address stack (RAS).

---
 rtl/y86_pkg.sv | 18 +
 rtl/pc_predict_unit_ras_stack.sv | 45 ++++
 rtl/pc_predict_unit.sv | 117 +++++++++++
 3 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 constants for the fetch-stage PC logic: icodes, FSM states
// and branch-prediction mode encodings.
package y86_pkg;

    localparam logic [3:0] ICODE_HALT = 4'h0;
    localparam logic [3:0] ICODE_JXX  = 4'h7;
    localparam logic [3:0] ICODE_CALL = 4'h8;
    localparam logic [3:0] ICODE_RET  = 4'h9;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fsm_state_t;

    localparam int PRED_ALWAYS_TAKEN = 0;
    localparam int PRED_BTFN         = 1;

endpackage

// File: rtl/pc_predict_unit_ras_stack.sv
// Circular return-address stack: overflow overwrites the oldest entry and
// saturates the count; a pop on an empty stack is ignored.
module ras_stack #(
    parameter  int ADDR_W = 64,
    parameter  int DEPTH  = 8,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top,
    output logic [CNT_W-1:0]  count,
    output logic              empty
);

    logic [ADDR_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  sp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp    <= '0;
            count <= '0;
        end else if (push) begin
            sp <= sp + 1'b1;
            if (count != CNT_W'(DEPTH))
                count <= count + 1'b1;
        end else if (pop && !empty) begin
            sp    <= sp - 1'b1;
            count <= count - 1'b1;
        end
    end

    // NOTE: entries need no reset; count gates every read of stale data.
    always_ff @(posedge clk) begin
        if (push)
            mem[sp] <= push_data;
    end

    assign top   = mem[sp - 1'b1];
    assign empty = (count == '0);

endmodule

// File: rtl/pc_predict_unit.sv
// Fetch PC select, branch/return prediction and halt FSM for the pipelined
// Y86-64 core. Optional return-address stack enabled by defining RAS_EN.
module pc_predict_unit
    import y86_pkg::*;
#(
    parameter  int                ADDR_W    = 64,
    parameter  logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter  int                PRED_MODE = PRED_ALWAYS_TAKEN,
    parameter  int                RAS_DEPTH = 8,
    localparam int                CNT_W     = $clog2(RAS_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              f_stall,
    input  logic [3:0]        f_icode,
    input  logic [ADDR_W-1:0] f_valC,
    input  logic [ADDR_W-1:0] f_valP,
    input  logic [3:0]        m_icode,
    input  logic              m_cnd,
    input  logic              m_pred_taken,
    input  logic [ADDR_W-1:0] m_valA,
    input  logic [ADDR_W-1:0] m_valC,
    input  logic [3:0]        w_icode,
    input  logic [ADDR_W-1:0] w_valM,
    input  logic [ADDR_W-1:0] w_pred_ret,
    output logic [ADDR_W-1:0] f_pc,
    output logic              f_pred_taken,
    output logic [ADDR_W-1:0] f_pred_ret,
    output logic              redirect,
    output logic              halted,
    output logic [CNT_W-1:0]  ras_count
);

    logic [ADDR_W-1:0] pred_pc, next_pred;
    logic [ADDR_W-1:0] ras_top;
    logic              ras_empty;
    logic              w_redir, m_redir, load_pc;
    fsm_state_t        state, state_nxt;

    assign m_redir  = (m_icode == ICODE_JXX) && (m_cnd != m_pred_taken);
    assign redirect = w_redir || m_redir;
    // A redirect always commits the fetch at f_pc, even under stall or in HALT.
    assign load_pc  = redirect || (state == RUN && !f_stall);
    assign halted   = (state == HALT);

`ifdef RAS_EN
    assign w_redir    = (w_icode == ICODE_RET) && (w_valM != w_pred_ret);
    assign f_pred_ret = (f_icode == ICODE_RET) ? (ras_empty ? f_valP : ras_top) : '0;

    ras_stack #(.ADDR_W(ADDR_W), .DEPTH(RAS_DEPTH)) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (load_pc && f_icode == ICODE_CALL),
        .pop       (load_pc && f_icode == ICODE_RET),
        .push_data (f_valP),
        .top       (ras_top),
        .count     (ras_count),
        .empty     (ras_empty)
    );
`else
    logic unused_pred_ret;

    assign w_redir         = (w_icode == ICODE_RET);
    assign f_pred_ret      = '0;
    assign ras_top         = '0;
    assign ras_empty       = 1'b1;
    assign ras_count       = '0;
    assign unused_pred_ret = ^w_pred_ret;
`endif

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        f_pc = pred_pc;
        if (w_redir)
            f_pc = w_valM;
        else if (m_redir)
            f_pc = m_cnd ? m_valC : m_valA;
    end

    always_comb begin
        f_pred_taken = 1'b0;
        if (f_icode == ICODE_JXX)
            f_pred_taken = (PRED_MODE == PRED_BTFN) ? (f_valC < f_valP) : 1'b1;
    end

    always_comb begin
        next_pred = f_valP;
        case (f_icode)
            ICODE_CALL: next_pred = f_valC;
            ICODE_JXX:  next_pred = f_pred_taken ? f_valC : f_valP;
            ICODE_RET:  next_pred = ras_empty ? f_valP : ras_top;
            default:    next_pred = f_valP;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:  if (f_icode == ICODE_HALT && !f_stall && !redirect) state_nxt = HALT;
            HALT: if (redirect) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_pc <= RESET_PC;
            state   <= RUN;
        end else begin
            state <= state_nxt;
            if (load_pc)
                pred_pc <= next_pred;
        end
    end

endmodule
